// File: rtl/alarm_scheduler_pkg.sv
// Shared types and constants for the dose alarm scheduler: FSM states,
// per-slot tone pitches and counter sizing helpers.
package alarm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    BEEP_ON,
    BEEP_OFF,
    GAP,
    TIMEOUT,
    RELEASE
  } alarm_state_e;

  // Tone generator half-period per slot; higher slots get higher pitches.
  localparam logic [18:0] TONE_TABLE [8] = '{
    19'd35768, 19'd31864, 19'd28409, 19'd23889,
    19'd21282, 19'd17897, 19'd15944, 19'd14204
  };

  function automatic int bits_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return bits_for(m);
  endfunction

endpackage

// File: rtl/alarm_scheduler_if.sv
// Request/acknowledge inputs, tone generator outputs and status/debug
// signals of the alarm scheduler, bundled for the top-level port.
interface alarm_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import alarm_pkg::*;

  // req_pulse, ack and clr_missed are single-cycle pulses sampled on the
  // rising clock edge; there is no backpressure, every pulse is consumed.
  logic [NUM_REQ-1:0] req_pulse;
  logic               ack;
  logic [NUM_REQ-1:0] clr_missed;
  logic               tone_enable;
  logic               beep;
  logic [18:0]        tone_delay;
  logic               active_valid;
  logic [2:0]         active_id;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] missed;
  logic               timeout_pulse;
  alarm_state_e       state;
  logic [2:0]         rr;

  modport master (
    output req_pulse, ack, clr_missed,
    input  tone_enable, beep, tone_delay, active_valid, active_id,
           pending, missed, timeout_pulse, state, rr
  );

  modport slave (
    input  req_pulse, ack, clr_missed,
    output tone_enable, beep, tone_delay, active_valid, active_id,
           pending, missed, timeout_pulse, state, rr
  );

endinterface

// File: rtl/alarm_scheduler_rr_picker.sv
// Combinational round-robin selector: first pending slot at or above rr,
// wrapping around to slot 0.
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [2:0]         rr,
  output logic [2:0]         grant_id,
  output logic               grant_valid
);

  logic [NUM_REQ-1:0] rot;

  always_comb begin
    rot         = NUM_REQ'({pending, pending} >> rr);
    grant_id    = '0;
    grant_valid = 1'b0;
    // Walk from the far end so the lowest rotated offset wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_valid = 1'b1;
        grant_id    = 3'((int'(rr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Dose alarm sequencer: grants the tone path to one requesting slot at a
// time and plays on/off beep bursts until acknowledge or timeout.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int BEEP_ON_CYCLES  = 12000000,
  parameter int BEEP_OFF_CYCLES = 12000000,
  parameter int GAP_CYCLES      = 50000000,
  parameter int BEEPS_PER_BURST = 3,
  parameter int MAX_BURSTS      = 20
) (
  input logic              CLOCK_50,
  input logic              reset,
  alarm_scheduler_if.slave bus
);

  localparam int CW = cnt_width(BEEP_ON_CYCLES, BEEP_OFF_CYCLES, GAP_CYCLES);
  localparam int BW = bits_for(BEEPS_PER_BURST);
  localparam int MW = bits_for(MAX_BURSTS);

  alarm_state_e       state_q, state_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic [BW-1:0]      beep_cnt_q, beep_cnt_n;
  logic [MW-1:0]      burst_q, burst_n;
  logic [2:0]         id_q, id_n, rr_q, rr_n;
  logic               valid_q, valid_n;
  logic [18:0]        delay_q, delay_n;
  logic [NUM_REQ-1:0] pending_q, pending_n, missed_q, missed_n;
  logic               beep_q, beep_n, tone_en_q, tone_en_n, tmo_q, tmo_n;
  logic               clr_active;
  logic [2:0]         grant_id;
  logic               grant_valid;
  logic               playing;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .pending     (pending_q),
    .rr          (rr_q),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign playing = (state_q == BEEP_ON) || (state_q == BEEP_OFF) || (state_q == GAP);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      beep_cnt_q <= '0;
      burst_q    <= '0;
      id_q       <= '0;
      rr_q       <= '0;
      valid_q    <= 1'b0;
      delay_q    <= '0;
      pending_q  <= '0;
      missed_q   <= '0;
      beep_q     <= 1'b0;
      tone_en_q  <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      beep_cnt_q <= beep_cnt_n;
      burst_q    <= burst_n;
      id_q       <= id_n;
      rr_q       <= rr_n;
      valid_q    <= valid_n;
      delay_q    <= delay_n;
      pending_q  <= pending_n;
      missed_q   <= missed_n;
      beep_q     <= beep_n;
      tone_en_q  <= tone_en_n;
      tmo_q      <= tmo_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    beep_cnt_n = beep_cnt_q;
    burst_n    = burst_q;
    id_n       = id_q;
    rr_n       = rr_q;
    valid_n    = valid_q;
    delay_n    = delay_q;
    missed_n   = missed_q & ~bus.clr_missed;
    pending_n  = pending_q;
    clr_active = 1'b0;

    if (playing && bus.ack) begin
      state_n    = RELEASE;
      clr_active = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (|pending_q) state_n = ARB;
        ARB: begin
          if (grant_valid) begin
            id_n       = grant_id;
            valid_n    = 1'b1;
            delay_n    = TONE_TABLE[grant_id];
            cnt_n      = '0;
            beep_cnt_n = '0;
            burst_n    = '0;
            state_n    = BEEP_ON;
          end else begin
            state_n = IDLE;
          end
        end
        BEEP_ON: begin
          if (cnt_q == CW'(BEEP_ON_CYCLES - 1)) begin
            cnt_n = '0;
            if (beep_cnt_q == BW'(BEEPS_PER_BURST - 1)) begin
              beep_cnt_n = '0;
              state_n    = GAP;
            end else begin
              beep_cnt_n = beep_cnt_q + BW'(1);
              state_n    = BEEP_OFF;
            end
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        BEEP_OFF: begin
          if (cnt_q == CW'(BEEP_OFF_CYCLES - 1)) begin
            cnt_n   = '0;
            state_n = BEEP_ON;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == CW'(GAP_CYCLES - 1)) begin
            cnt_n   = '0;
            burst_n = burst_q + MW'(1);
            state_n = (burst_q == MW'(MAX_BURSTS - 1)) ? TIMEOUT : BEEP_ON;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        TIMEOUT: begin
          clr_active = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (id_q == 3'(i)) missed_n[i] = 1'b1;
          end
          state_n = RELEASE;
        end
        RELEASE: begin
          rr_n    = (id_q == 3'(NUM_REQ - 1)) ? 3'd0 : id_q + 3'd1;
          valid_n = 1'b0;
          id_n    = '0;
          delay_n = '0;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    // Clear first, then set, so a fresh request re-arms the retiring slot.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (clr_active && (id_q == 3'(i))) pending_n[i] = 1'b0;
    end
    pending_n = pending_n | bus.req_pulse;

    beep_n    = (state_n == BEEP_ON);
    tone_en_n = (state_n == BEEP_ON) || (state_n == BEEP_OFF) || (state_n == GAP);
    tmo_n     = (state_n == TIMEOUT);
  end

  assign bus.tone_enable   = tone_en_q;
  assign bus.beep          = beep_q;
  assign bus.tone_delay    = delay_q;
  assign bus.active_valid  = valid_q;
  assign bus.active_id     = id_q;
  assign bus.pending       = pending_q;
  assign bus.missed        = missed_q;
  assign bus.timeout_pulse = tmo_q;
  assign bus.state         = state_q;
  assign bus.rr            = rr_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler with shortened beep timing.
module tb_alarm_scheduler;
  import alarm_pkg::*;

  localparam int NR = 4, ON = 4, OFF = 2, GP = 6, BEEPS = 3, BURSTS = 2;
  localparam logic [18:0] PITCH [4] = '{19'd35768, 19'd31864, 19'd28409, 19'd23889};

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   total    = 0;
  int   bad      = 0;
  logic [31:0] exp_q[$];

  alarm_scheduler_if #(.NUM_REQ(NR)) bus();

  alarm_scheduler #(
    .NUM_REQ(NR), .BEEP_ON_CYCLES(ON), .BEEP_OFF_CYCLES(OFF),
    .GAP_CYCLES(GP), .BEEPS_PER_BURST(BEEPS), .MAX_BURSTS(BURSTS)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  // clock / reset
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // drivers: change inputs on the falling edge, hold for one cycle
  task automatic pulse_req(input logic [NR-1:0] v);
    bus.req_pulse = v;
    tick();
    bus.req_pulse = '0;
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] obs;
    do_reset();
    obs = {bus.tone_enable, bus.beep, bus.tone_delay, bus.active_valid,
           bus.active_id, bus.timeout_pulse};
    total++;
    if (obs !== 32'd0) begin
      bad++; $display("FAIL reset_outputs: got %h, wanted 0", obs);
    end
    total++;
    if ({bus.pending, bus.missed} !== 8'd0 || bus.state !== IDLE || bus.rr !== 3'd0) begin
      bad++; $display("FAIL reset_regs: pending=%b missed=%b state=%0d rr=%0d, wanted 0",
                      bus.pending, bus.missed, int'(bus.state), bus.rr);
    end
  endtask

  task automatic test_single();
    logic [31:0] e, obs;
    int idx;
    do_reset();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    for (int b = 0; b < BURSTS; b++) begin
      for (int k = 0; k < BEEPS; k++) begin
        repeat (ON) exp_q.push_back(32'b011);
        if (k < BEEPS - 1) repeat (OFF) exp_q.push_back(32'b010);
      end
      repeat (GP) exp_q.push_back(32'b010);
    end
    exp_q.push_back(32'b100);
    exp_q.push_back(32'b000);
    pulse_req(4'b0001);
    idx = 0;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = {29'd0, bus.timeout_pulse, bus.tone_enable, bus.beep};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL single_pattern[%0d]: {tmo,en,beep}=%b, wanted %b", idx, obs[2:0], e[2:0]);
      end
      idx++;
      if (exp_q.size() > 0) tick();
    end
    total++;
    if (bus.missed !== 4'b0001 || bus.pending !== 4'b0000) begin
      bad++; $display("FAIL single_timeout: missed=%b pending=%b, wanted 0001 0000", bus.missed, bus.pending);
    end
    tick();
    total++;
    if (bus.active_valid !== 1'b0 || bus.tone_delay !== 19'd0 || bus.state !== IDLE) begin
      bad++; $display("FAIL single_release: valid=%b delay=%0d state=%0d, wanted 0 0 IDLE",
                      bus.active_valid, bus.tone_delay, int'(bus.state));
    end
  endtask

  task automatic test_reset_mid_gap();
    int n;
    pulse_req(4'b0001);
    n = 0;
    while (bus.state !== GAP && n < 40) begin tick(); n++; end
    total++;
    if (bus.state !== GAP) begin
      bad++; $display("FAIL gap_reached: state=%0d, wanted GAP", int'(bus.state));
    end
    pulse_req(4'b0010);
    total++;
    if (bus.pending !== 4'b0011 || bus.missed !== 4'b0001) begin
      bad++; $display("FAIL gap_prereset: pending=%b missed=%b, wanted 0011 0001", bus.pending, bus.missed);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({bus.tone_enable, bus.beep, bus.tone_delay, bus.active_valid, bus.active_id,
         bus.timeout_pulse, bus.pending, bus.missed} !== 34'd0 || bus.state !== IDLE) begin
      bad++; $display("FAIL gap_reset: en=%b beep=%b valid=%b pending=%b missed=%b state=%0d, wanted all 0 IDLE",
                      bus.tone_enable, bus.beep, bus.active_valid, bus.pending, bus.missed, int'(bus.state));
    end
    repeat (4) tick();
    total++;
    if (bus.state !== IDLE || bus.active_valid !== 1'b0) begin
      bad++; $display("FAIL gap_lost_req: state=%0d valid=%b, wanted IDLE 0", int'(bus.state), bus.active_valid);
    end
  endtask

  task automatic test_ack_mid();
    do_reset();
    pulse_req(4'b0001);
    tick();
    tick();
    total++;
    if (bus.beep !== 1'b1) begin
      bad++; $display("FAIL ack_beep_start: beep=%b, wanted 1", bus.beep);
    end
    tick();
    pulse_ack();
    total++;
    if (bus.beep !== 1'b0 || bus.state !== RELEASE || bus.pending !== 4'b0000) begin
      bad++; $display("FAIL ack_release: beep=%b state=%0d pending=%b, wanted 0 RELEASE 0000",
                      bus.beep, int'(bus.state), bus.pending);
    end
    tick();
    total++;
    if (bus.state !== IDLE || bus.missed !== 4'b0000 || bus.active_valid !== 1'b0) begin
      bad++; $display("FAIL ack_idle: state=%0d missed=%b valid=%b, wanted IDLE 0000 0",
                      int'(bus.state), bus.missed, bus.active_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] e, obs;
    int n;
    do_reset();
    exp_q.push_back({10'd0, 3'd0, PITCH[0]});
    exp_q.push_back({10'd0, 3'd1, PITCH[1]});
    exp_q.push_back({10'd0, 3'd3, PITCH[3]});
    pulse_req(4'b1011);
    while (exp_q.size() > 0) begin
      n = 0;
      while (bus.active_valid !== 1'b1 && n < 10) begin tick(); n++; end
      e   = exp_q.pop_front();
      obs = {10'd0, bus.active_id, bus.tone_delay};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL rr_grant: id=%0d delay=%0d, wanted id=%0d delay=%0d",
                        obs[21:19], obs[18:0], e[21:19], e[18:0]);
      end
      pulse_ack();
      n = 0;
      while (bus.active_valid !== 1'b0 && n < 10) begin tick(); n++; end
    end
    total++;
    if (bus.rr !== 3'd0 || bus.pending !== 4'b0000 || bus.state !== IDLE) begin
      bad++; $display("FAIL rr_end: rr=%0d pending=%b state=%0d, wanted 0 0000 IDLE",
                      bus.rr, bus.pending, int'(bus.state));
    end
  endtask

  task automatic test_rerequest();
    logic [31:0] e, obs;
    int n;
    do_reset();
    pulse_req(4'b0100);
    n = 0;
    while (bus.active_valid !== 1'b1 && n < 10) begin tick(); n++; end
    exp_q.push_back(32'(RELEASE));
    exp_q.push_back(32'(IDLE));
    exp_q.push_back(32'(ARB));
    exp_q.push_back(32'(BEEP_ON));
    bus.ack       = 1'b1;
    bus.req_pulse = 4'b0100;
    tick();
    bus.ack       = 1'b0;
    bus.req_pulse = '0;
    total++;
    if (bus.pending !== 4'b0100) begin
      bad++; $display("FAIL rereq_pending: pending=%b, wanted 0100", bus.pending);
    end
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = 32'(bus.state);
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL rereq_state: state=%0d, wanted %0d", obs, e);
      end
      if (exp_q.size() > 0) tick();
    end
    total++;
    if (bus.active_id !== 3'd2 || bus.active_valid !== 1'b1 || bus.beep !== 1'b1) begin
      bad++; $display("FAIL rereq_grant: id=%0d valid=%b beep=%b, wanted 2 1 1",
                      bus.active_id, bus.active_valid, bus.beep);
    end
  endtask

  task automatic test_timeout_clr();
    int n;
    do_reset();
    pulse_req(4'b0001);
    n = 0;
    while (bus.timeout_pulse !== 1'b1 && n < 100) begin tick(); n++; end
    total++;
    if (bus.timeout_pulse !== 1'b1) begin
      bad++; $display("FAIL tmo_seen: timeout_pulse=%b, wanted 1", bus.timeout_pulse);
    end
    bus.clr_missed = 4'b0001;
    tick();
    bus.clr_missed = '0;
    total++;
    if (bus.missed !== 4'b0001) begin
      bad++; $display("FAIL tmo_clr_collide: missed=%b, wanted 0001", bus.missed);
    end
    tick();
    pulse_ack();
    total++;
    if (bus.state !== IDLE || bus.missed !== 4'b0001 || bus.pending !== 4'b0000 || bus.tone_enable !== 1'b0) begin
      bad++; $display("FAIL idle_ack: state=%0d missed=%b pending=%b en=%b, wanted IDLE 0001 0000 0",
                      int'(bus.state), bus.missed, bus.pending, bus.tone_enable);
    end
    bus.clr_missed = 4'b0001;
    tick();
    bus.clr_missed = '0;
    total++;
    if (bus.missed !== 4'b0000) begin
      bad++; $display("FAIL clr_missed: missed=%b, wanted 0000", bus.missed);
    end
  endtask

  initial begin
    bus.req_pulse  = '0;
    bus.ack        = 1'b0;
    bus.clr_missed = '0;
    test_reset();
    test_single();
    test_reset_mid_gap();
    test_ack_mid();
    test_round_robin();
    test_rerequest();
    test_timeout_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
